servo_pwm_bank: RTL and testbench

//  Multi-channel servo PWM generator; parametrised successor of the single-channel serializer.
//  One shared period counter drives NUM_CH outputs. Each output's pulse = BASE + duty*STEP clocks.

---
 rtl/servo_pwm_bank.sv | 120 ++++++++++++
 tb/tb_servo_pwm_bank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: one shared frame counter, per-channel duty
// targets committed (optionally slew-limited) only at the frame boundary.
module servo_pwm_bank #(
    parameter int NUM_CH   = 4,
    parameter int PERIOD   = 2000000,
    parameter int BASE     = 50000,
    parameter int STEP     = 2000,
    parameter int DUTY_W   = 7,
    parameter int DUTY_MAX = 99,
    parameter int SLEW     = 0,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic [DUTY_W-1:0] wr_duty_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              frame_start_o,
    output logic [NUM_CH-1:0] settled_o
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("servo_pwm_bank: NUM_CH must be in 1..16");
    end
    if (BASE + DUTY_MAX * STEP >= PERIOD) begin : g_bad_limit
        $error("servo_pwm_bank: BASE + DUTY_MAX*STEP must be below PERIOD");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DUTY_W-1:0] target_q [NUM_CH];
    logic [DUTY_W-1:0] target_d [NUM_CH];
    logic [DUTY_W-1:0] active_q [NUM_CH];
    logic [DUTY_W-1:0] active_d [NUM_CH];
    logic [DUTY_W-1:0] diff_s   [NUM_CH];
    logic [CNT_W-1:0]  limit_q  [NUM_CH];
    logic [CNT_W-1:0]  limit_d  [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, pwm_q, pwm_d;
    logic              frame_start_q;
    logic              boundary_s, wr_fire_s;
    logic [DUTY_W-1:0] wr_clamped_s;

    assign boundary_s   = (cnt_q == CNT_W'(PERIOD - 1));
    // The boundary cycle is reserved for committing targets, so writes stall there.
    assign wr_ready_o   = ~reset & ~boundary_s;
    assign wr_fire_s    = wr_valid_i & wr_ready_o;
    assign wr_clamped_s = (int'(wr_duty_i) > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : wr_duty_i;

    // Next-state: frame counter, targets, boundary commit and pwm compare.
    always_comb begin
        cnt_d = boundary_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        en_d  = boundary_s ? ch_en_i : en_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_fire_s && (int'(wr_ch_i) == i)) begin
                target_d[i] = wr_clamped_s;
            end else begin
                target_d[i] = target_q[i];
            end

            if (target_q[i] >= active_q[i]) begin
                diff_s[i] = target_q[i] - active_q[i];
            end else begin
                diff_s[i] = active_q[i] - target_q[i];
            end

            if (!boundary_s) begin
                active_d[i] = active_q[i];
            end else if (SLEW == 0 || int'(diff_s[i]) <= SLEW) begin
                active_d[i] = target_q[i];
            end else if (target_q[i] > active_q[i]) begin
                active_d[i] = active_q[i] + DUTY_W'(SLEW);
            end else begin
                active_d[i] = active_q[i] - DUTY_W'(SLEW);
            end

            // Parameter check guarantees the limit is below PERIOD, so it fits CNT_W.
            limit_d[i] = boundary_s ? CNT_W'(BASE + int'(active_d[i]) * STEP) : limit_q[i];
            pwm_d[i]   = en_q[i] & (cnt_q < limit_q[i]);
        end
    end

    // State registers; reset drops pwm immediately and restarts the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= {CNT_W{1'b0}};
            en_q          <= {NUM_CH{1'b0}};
            pwm_q         <= {NUM_CH{1'b0}};
            frame_start_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= {DUTY_W{1'b0}};
                active_q[i] <= {DUTY_W{1'b0}};
                limit_q[i]  <= CNT_W'(BASE);
            end
        end else begin
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            pwm_q         <= pwm_d;
            frame_start_q <= boundary_s;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= target_d[i];
                active_q[i] <= active_d[i];
                limit_q[i]  <= limit_d[i];
            end
        end
    end

    // Per-channel settled flag straight from the committed/target registers.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            settled_o[i] = (active_q[i] == target_q[i]);
        end
    end

    assign pwm_o         = pwm_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Randomized bench for servo_pwm_bank: two instances (no slew, slew 5) checked
// every cycle against a frame-level model of targets, committed duty and enables.
module tb_servo_pwm_bank;
    localparam int NUM_CH   = 2;
    localparam int PERIOD   = 100;
    localparam int BASE     = 10;
    localparam int STEP     = 1;
    localparam int DUTY_W   = 7;
    localparam int DUTY_MAX = 50;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              wr_valid = 1'b0;
    logic [0:0]        wr_ch    = 1'b0;
    logic [DUTY_W-1:0] wr_duty  = '0;
    logic [1:0]        ch_en    = 2'b00;
    logic              wr_ready_s [2];
    logic [1:0]        pwm_s      [2];
    logic              fs_s       [2];
    logic [1:0]        settled_s  [2];

    int checks   = 0;
    int failures = 0;
    int tcnt     = 0;
    logic [1:0] en_v = 2'b11;
    int slew_m   [2] = '{0, 5};
    int target_m [2][2];
    int active_m [2][2];
    int en_m     [2][2];

    servo_pwm_bank #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .BASE(BASE), .STEP(STEP),
                     .DUTY_W(DUTY_W), .DUTY_MAX(DUTY_MAX), .SLEW(0)) u_dut0 (
        .clk(clk), .reset(reset), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_s[0]),
        .wr_ch_i(wr_ch), .wr_duty_i(wr_duty), .ch_en_i(ch_en), .pwm_o(pwm_s[0]),
        .frame_start_o(fs_s[0]), .settled_o(settled_s[0]));

    servo_pwm_bank #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .BASE(BASE), .STEP(STEP),
                     .DUTY_W(DUTY_W), .DUTY_MAX(DUTY_MAX), .SLEW(5)) u_dut1 (
        .clk(clk), .reset(reset), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_s[1]),
        .wr_ch_i(wr_ch), .wr_duty_i(wr_duty), .ch_en_i(ch_en), .pwm_o(pwm_s[1]),
        .frame_start_o(fs_s[1]), .settled_o(settled_s[1]));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t frame_cnt=%0d)", tag, got, exp, $time, tcnt);
        end
    endtask

    // Expected outputs for the cycle in which the DUT counter reads tcnt.
    task automatic check_outputs();
        logic [1:0] ep, es;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                ep[c] = (en_m[d][c] != 0) && (tcnt != 0) && (tcnt <= BASE + active_m[d][c] * STEP);
                es[c] = (active_m[d][c] == target_m[d][c]);
            end
            check_val($sformatf("pwm%0d", d), 32'(pwm_s[d]), 32'(ep));
            check_val($sformatf("settled%0d", d), 32'(settled_s[d]), 32'(es));
            check_val($sformatf("frame_start%0d", d), 32'(fs_s[d]), 32'(tcnt == 0));
            check_val($sformatf("wr_ready%0d", d), 32'(wr_ready_s[d]), 32'(tcnt != PERIOD - 1));
        end
    endtask

    // Drive one cycle of inputs and advance the model across the next edge.
    task automatic advance(input logic v, input int ch, input int duty, input logic [1:0] en);
        int diff;
        wr_valid = v;
        wr_ch    = 1'(ch);
        wr_duty  = DUTY_W'(duty);
        ch_en    = en;
        for (int d = 0; d < 2; d++) begin
            if (v && tcnt != PERIOD - 1 && ch < NUM_CH)
                target_m[d][ch] = (duty > DUTY_MAX) ? DUTY_MAX : duty;
            if (tcnt == PERIOD - 1) begin
                for (int c = 0; c < 2; c++) begin
                    diff = target_m[d][c] - active_m[d][c];
                    if (slew_m[d] == 0 || (diff <= slew_m[d] && diff >= -slew_m[d]))
                        active_m[d][c] = target_m[d][c];
                    else if (diff > 0)
                        active_m[d][c] += slew_m[d];
                    else
                        active_m[d][c] -= slew_m[d];
                    en_m[d][c] = int'(en[c]);
                end
            end
        end
        tcnt = (tcnt + 1) % PERIOD;
    endtask

    task automatic cycle(input logic v, input int ch, input int duty);
        @(negedge clk);
        check_outputs();
        advance(v, ch, duty, en_v);
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0);
    endtask

    task automatic run_to(input int k);
        while (tcnt != k) cycle(1'b0, 0, 0);
    endtask

    task automatic write_at(input int k, input int ch, input int duty);
        run_to(k);
        cycle(1'b1, ch, duty);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                target_m[d][c] = 0;
                active_m[d][c] = 0;
                en_m[d][c]     = 0;
            end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_val("rst_pwm", 32'(pwm_s[d]), 32'd0);
                check_val("rst_frame_start", 32'(fs_s[d]), 32'd0);
                check_val("rst_wr_ready", 32'(wr_ready_s[d]), 32'd0);
                check_val("rst_settled", 32'(settled_s[d]), 32'd3);
            end
        end
        reset = 1'b0;
        tcnt  = 0;
        // The half-cycle after release (counter at 0) is not sampled.
        advance(1'b0, 0, 0, en_v);
    endtask

    initial begin
        reset = 1'b1;
        en_v  = 2'b11;
        do_reset();
        run_cycles(3 * PERIOD);

        write_at(40, 0, 20);
        run_cycles(5 * PERIOD);

        write_at(30, 0, 90);
        write_at(PERIOD - 1, 1, 40);
        run_cycles(3 * PERIOD);

        run_to(50);
        en_v = 2'b01;
        run_cycles(2 * PERIOD);
        en_v = 2'b11;
        run_cycles(2 * PERIOD);

        for (int k = 0; k < 25 * PERIOD; k++) begin
            if ($urandom_range(0, 149) == 0) en_v = 2'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 127));
        end

        en_v = 2'b11;
        run_cycles(2 * PERIOD);
        run_to(5);
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        #1;
        check_val("async_rst_pwm0", 32'(pwm_s[0]), 32'd0);
        check_val("async_rst_pwm1", 32'(pwm_s[1]), 32'd0);
        do_reset();
        run_cycles(3 * PERIOD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
